// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the cpu_sequencer instruction sequencer:
// FSM states, opcode classes, bus selects and jump conditions.
package cpu_seq_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_OPERAND,
      ST_DATA,
      ST_EXEC,
      ST_HALT
   } seq_state_t;

   localparam logic [1:0] OPC_LOAD = 2'b00;
   localparam logic [1:0] OPC_ALU  = 2'b01;
   localparam logic [1:0] OPC_JMP  = 2'b10;
   localparam logic [1:0] OPC_CTRL = 2'b11;

   localparam logic [1:0] BUS_INPUT = 2'd0;
   localparam logic [1:0] BUS_MEM   = 2'd1;
   localparam logic [1:0] BUS_ALU   = 2'd2;

   localparam logic [1:0] COND_ALWAYS = 2'b00;
   localparam logic [1:0] COND_ZERO   = 2'b01;
   localparam logic [1:0] COND_CARRY  = 2'b10;
   localparam logic [1:0] COND_SIGN   = 2'b11;

   function automatic logic cond_met(input logic [1:0] cond, input logic zero_f,
                                     input logic carry_f, input logic sign_f);
      logic met;
      case (cond)
         COND_ALWAYS: met = 1'b1;
         COND_ZERO:   met = zero_f;
         COND_CARRY:  met = carry_f;
         default:     met = sign_f;
      endcase
      return met;
   endfunction

   function automatic logic [3:0] reg_onehot(input logic [1:0] sel);
      return 4'b0001 << sel;
   endfunction

endpackage

// File: rtl/cpu_seq_call_stack.sv
// Return-address LIFO for call/return; push when full and pop when empty
// are ignored here, the sequencer flags them as stack errors.
module cpu_seq_call_stack #(
   parameter int STACK_DEPTH = 4,
   parameter int PC_W        = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] din,
   output logic [PC_W-1:0] dout,
   output logic            full,
   output logic            empty
);

   localparam int CNT_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [PC_W-1:0]  mem [STACK_DEPTH];
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] top;

   assign full  = (count == CNT_W'(STACK_DEPTH));
   assign empty = (count == '0);
   assign top   = count - 1'b1;
   assign dout  = empty ? '0 : mem[top[IDX_W-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + 1'b1;
      end else if (pop && !empty) begin
         count <= count - 1'b1;
      end
   end

   // Entry storage needs no reset: only slots below count are ever read.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[count[IDX_W-1:0]] <= din;
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetches over a req/ack handshake,
// decodes, drives datapath control pulses, jumps and call/return.
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int WORD_W      = 8,
   parameter int PC_W        = 8,
   parameter int REG_COUNT   = 4,
   parameter int STACK_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 mem_req,
   output logic [PC_W-1:0]      mem_addr,
   input  logic                 mem_ack,
   input  logic [WORD_W-1:0]    mem_rdata,
   input  logic                 zero_flag,
   input  logic                 carry_flag,
   input  logic                 sign_flag,
   output logic [1:0]           bus_sel,
   output logic [REG_COUNT-1:0] reg_load,
   output logic                 out_load,
   output logic                 alu_en,
   output logic [2:0]           alu_op,
   output logic                 alu_a_sel,
   output logic                 alu_b_sel,
   output logic                 alu_shift,
   output logic                 halted,
   output logic                 stack_err
);

   seq_state_t        state, state_n;
   logic [PC_W-1:0]   pc, pc_n;
   logic [PC_W-1:0]   opa, opa_n;
   logic [WORD_W-1:0] ir, ir_n;
   logic [WORD_W-1:0] opnd, opnd_n;
   logic              err_n;

   logic              stack_push, stack_pop;
   logic              stack_full, stack_empty;
   logic [PC_W-1:0]   stack_dout;

   logic [PC_W-1:0]   opnd_abs;
   logic [PC_W-1:0]   opnd_rel;

   // Absolute targets zero-extend the operand, relative offsets sign-extend it.
   if (WORD_W >= PC_W) begin : g_opnd_trunc
      assign opnd_abs = opnd[PC_W-1:0];
      assign opnd_rel = opnd[PC_W-1:0];
   end else begin : g_opnd_extend
      assign opnd_abs = {{(PC_W-WORD_W){1'b0}}, opnd};
      assign opnd_rel = {{(PC_W-WORD_W){opnd[WORD_W-1]}}, opnd};
   end

   cpu_seq_call_stack #(
      .STACK_DEPTH(STACK_DEPTH),
      .PC_W       (PC_W)
   ) u_call_stack (
      .clk  (clk),
      .rst  (rst),
      .push (stack_push),
      .pop  (stack_pop),
      .din  (pc),
      .dout (stack_dout),
      .full (stack_full),
      .empty(stack_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_FETCH;
         pc        <= '0;
         opa       <= '0;
         ir        <= '0;
         opnd      <= '0;
         stack_err <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         opa       <= opa_n;
         ir        <= ir_n;
         opnd      <= opnd_n;
         stack_err <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      opa_n      = opa;
      ir_n       = ir;
      opnd_n     = opnd;
      err_n      = stack_err;
      stack_push = 1'b0;
      stack_pop  = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      bus_sel    = BUS_INPUT;
      reg_load   = '0;
      out_load   = 1'b0;
      alu_en     = 1'b0;
      alu_op     = 3'd0;
      alu_a_sel  = 1'b0;
      alu_b_sel  = 1'b0;
      alu_shift  = 1'b0;
      halted     = 1'b0;

      case (state)
         ST_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc;
            if (mem_ack) begin
               ir_n    = mem_rdata;
               pc_n    = pc + 1'b1;
               state_n = ST_DECODE;
            end
         end

         ST_DECODE: begin
            state_n = ST_FETCH;
            case (ir[7:6])
               OPC_LOAD: begin
                  if (ir[5]) begin
                     out_load = 1'b1;
                     bus_sel  = BUS_ALU;
                  end else if (ir[4]) begin
                     state_n = ST_OPERAND;
                  end else begin
                     reg_load = REG_COUNT'(reg_onehot(ir[3:2]));
                     bus_sel  = BUS_INPUT;
                  end
               end
               OPC_ALU: begin
                  alu_en    = 1'b1;
                  alu_op    = ir[5:3];
                  alu_a_sel = ir[2];
                  alu_b_sel = ir[1];
                  alu_shift = ir[0];
               end
               OPC_JMP: begin
                  state_n = ST_OPERAND;
               end
               default: begin
                  if (!ir[5]) begin
                     state_n = ST_OPERAND;
                  end else if (ir[4]) begin
                     state_n = ST_HALT;
                  end else if (stack_empty) begin
                     err_n   = 1'b1;
                     state_n = ST_HALT;
                  end else begin
                     stack_pop = 1'b1;
                     pc_n      = stack_dout;
                  end
               end
            endcase
         end

         // OPA keeps the operand's own address as the base for relative jumps.
         ST_OPERAND: begin
            mem_req  = 1'b1;
            mem_addr = pc;
            if (mem_ack) begin
               opnd_n  = mem_rdata;
               opa_n   = pc;
               pc_n    = pc + 1'b1;
               state_n = (ir[7:6] == OPC_LOAD) ? ST_DATA : ST_EXEC;
            end
         end

         ST_DATA: begin
            mem_req  = 1'b1;
            mem_addr = opnd_abs;
            if (mem_ack) begin
               reg_load = REG_COUNT'(reg_onehot(ir[3:2]));
               bus_sel  = BUS_MEM;
               state_n  = ST_FETCH;
            end
         end

         ST_EXEC: begin
            state_n = ST_FETCH;
            if (ir[7:6] == OPC_JMP) begin
               if (cond_met(ir[5:4], zero_flag, carry_flag, sign_flag)) begin
                  pc_n = ir[3] ? opnd_abs : (opa + opnd_rel);
               end
            end else if (stack_full) begin
               err_n   = 1'b1;
               state_n = ST_HALT;
            end else begin
               stack_push = 1'b1;
               pc_n       = opnd_abs;
            end
         end

         ST_HALT: begin
            halted = 1'b1;
         end

         default: begin
            state_n = ST_FETCH;
         end
      endcase

      // An in-flight request must vanish the moment reset is asserted.
      if (rst) begin
         mem_req  = 1'b0;
         mem_addr = '0;
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: expected memory reads and control
// pulses are queued with their cycle numbers and matched against a monitor.
module tb_cpu_sequencer;

   localparam int WORD_W      = 8;
   localparam int PC_W        = 8;
   localparam int REG_COUNT   = 4;
   localparam int STACK_DEPTH = 4;

   localparam int K_MEM = 1;
   localparam int K_REG = 2;
   localparam int K_OUT = 3;
   localparam int K_ALU = 4;

   logic                 clk;
   logic                 rst;
   logic                 mem_req;
   logic [PC_W-1:0]      mem_addr;
   logic                 mem_ack;
   logic [WORD_W-1:0]    mem_rdata;
   logic                 zero_flag, carry_flag, sign_flag;
   logic [1:0]           bus_sel;
   logic [REG_COUNT-1:0] reg_load;
   logic                 out_load;
   logic                 alu_en;
   logic [2:0]           alu_op;
   logic                 alu_a_sel, alu_b_sel, alu_shift;
   logic                 halted;
   logic                 stack_err;

   logic [7:0]  prog [256];
   int          ack_delay;
   int          wait_cnt;
   int          cyc;
   int          idle_bad;
   logic [31:0] exp_q [$];
   logic [31:0] obs_q [$];
   int          pass_cnt;
   int          total_cnt;

   cpu_sequencer #(
      .WORD_W     (WORD_W),
      .PC_W       (PC_W),
      .REG_COUNT  (REG_COUNT),
      .STACK_DEPTH(STACK_DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .zero_flag (zero_flag),
      .carry_flag(carry_flag),
      .sign_flag (sign_flag),
      .bus_sel   (bus_sel),
      .reg_load  (reg_load),
      .out_load  (out_load),
      .alu_en    (alu_en),
      .alu_op    (alu_op),
      .alu_a_sel (alu_a_sel),
      .alu_b_sel (alu_b_sel),
      .alu_shift (alu_shift),
      .halted    (halted),
      .stack_err (stack_err)
   );

   always #5 clk = ~clk;

   // Program memory with a programmable number of wait cycles per request.
   assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
   assign mem_rdata = prog[mem_addr];

   always @(posedge clk) begin
      if (!mem_req || mem_ack) wait_cnt <= 0;
      else                     wait_cnt <= wait_cnt + 1;
   end

   function automatic logic [31:0] ev(input int c, input int k, input logic [11:0] d);
      return {c[15:0], k[3:0], d};
   endfunction

   // Monitor: cycle 1 is the first cycle after reset is released.
   always @(negedge clk) begin
      if (rst) begin
         cyc = 0;
      end else begin
         cyc = cyc + 1;
         if (mem_req && mem_ack) obs_q.push_back(ev(cyc, K_MEM, 12'(mem_addr)));
         if (reg_load != '0)     obs_q.push_back(ev(cyc, K_REG, 12'({bus_sel, reg_load})));
         if (out_load)           obs_q.push_back(ev(cyc, K_OUT, 12'(bus_sel)));
         if (alu_en)             obs_q.push_back(ev(cyc, K_ALU, 12'({alu_op, alu_a_sel, alu_b_sel, alu_shift})));
         if (!alu_en && ({alu_op, alu_a_sel, alu_b_sel, alu_shift} != 6'd0)) idle_bad = idle_bad + 1;
         if (reg_load == '0 && !out_load && bus_sel != 2'd0) idle_bad = idle_bad + 1;
      end
   end

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 8'hF0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      obs_q.delete();
      exp_q.delete();
      #1 rst = 1'b0;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [19:0] outs;
      rst = 1'b1;
      @(posedge clk);
      #1;
      outs = {mem_req, reg_load, out_load, alu_en, bus_sel, alu_op,
              alu_a_sel, alu_b_sel, alu_shift, halted, stack_err, mem_addr[1:0]};
      total_cnt++;
      if (outs !== 20'd0) $display("[TB] FAIL reset_outputs: got %h want 0", outs);
      else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++;
      if ({mem_req, mem_addr} !== {1'b1, 8'h00})
         $display("[TB] FAIL reset_first_fetch: got req=%b addr=%h want req=1 addr=00", mem_req, mem_addr);
      else pass_cnt++;
   endtask

   task automatic test_zero_wait();
      logic [31:0] want, got;
      clear_prog();
      prog[0] = 8'h04;
      prog[1] = 8'h6B;
      ack_delay = 0;
      do_reset();
      idle_bad = 0;
      exp_q.push_back(ev(1, K_MEM, 12'h000));
      exp_q.push_back(ev(2, K_REG, 12'h002));
      exp_q.push_back(ev(3, K_MEM, 12'h001));
      exp_q.push_back(ev(4, K_ALU, 12'h02B));
      exp_q.push_back(ev(5, K_MEM, 12'h002));
      run_cycles(10);
      total_cnt++;
      if (obs_q.size() != exp_q.size())
         $display("[TB] FAIL zw_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
      else pass_cnt++;
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
         total_cnt++;
         if (got !== want) $display("[TB] FAIL zw_event: got %h want %h", got, want);
         else pass_cnt++;
      end
      total_cnt++;
      if (idle_bad != 0) $display("[TB] FAIL zw_idle_selects: got %0d stray cycles want 0", idle_bad);
      else pass_cnt++;
      total_cnt++;
      if ({halted, mem_req} !== 2'b10)
         $display("[TB] FAIL zw_halt: got halted=%b req=%b want halted=1 req=0", halted, mem_req);
      else pass_cnt++;
   endtask

   task automatic test_jump(input string name, input logic [7:0] op, input logic [7:0] opnd,
                            input logic zf, input logic cf, input logic sf, input logic [7:0] target);
      logic [31:0] want, got;
      clear_prog();
      prog[0] = op;
      prog[1] = opnd;
      zero_flag  = zf;
      carry_flag = cf;
      sign_flag  = sf;
      ack_delay  = 0;
      do_reset();
      exp_q.push_back(ev(1, K_MEM, 12'h000));
      exp_q.push_back(ev(3, K_MEM, 12'h001));
      exp_q.push_back(ev(5, K_MEM, 12'(target)));
      run_cycles(9);
      total_cnt++;
      if (obs_q.size() != exp_q.size())
         $display("[TB] FAIL %s_event_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
      else pass_cnt++;
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
         total_cnt++;
         if (got !== want) $display("[TB] FAIL %s_event: got %h want %h", name, got, want);
         else pass_cnt++;
      end
      zero_flag  = 1'b0;
      carry_flag = 1'b0;
      sign_flag  = 1'b0;
   endtask

   task automatic test_call_return();
      logic [31:0] want, got;
      clear_prog();
      prog[0]    = 8'hC0;
      prog[1]    = 8'h20;
      prog[8'h20] = 8'hE0;
      prog[2]    = 8'h24;
      ack_delay = 0;
      do_reset();
      exp_q.push_back(ev(1, K_MEM, 12'h000));
      exp_q.push_back(ev(3, K_MEM, 12'h001));
      exp_q.push_back(ev(5, K_MEM, 12'h020));
      exp_q.push_back(ev(7, K_MEM, 12'h002));
      exp_q.push_back(ev(8, K_OUT, 12'h002));
      exp_q.push_back(ev(9, K_MEM, 12'h003));
      run_cycles(14);
      total_cnt++;
      if (obs_q.size() != exp_q.size())
         $display("[TB] FAIL call_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
      else pass_cnt++;
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
         total_cnt++;
         if (got !== want) $display("[TB] FAIL call_event: got %h want %h", got, want);
         else pass_cnt++;
      end
      total_cnt++;
      if ({halted, stack_err} !== 2'b10)
         $display("[TB] FAIL call_end_state: got halted=%b err=%b want halted=1 err=0", halted, stack_err);
      else pass_cnt++;
   endtask

   task automatic test_stack_overflow();
      logic [31:0] want, got;
      clear_prog();
      for (int i = 0; i <= STACK_DEPTH; i++) begin
         prog[8'(i * 16)]     = 8'hC0;
         prog[8'(i * 16 + 1)] = 8'((i + 1) * 16);
         exp_q.push_back(ev(4 * i + 1, K_MEM, 12'(i * 16)));
         exp_q.push_back(ev(4 * i + 3, K_MEM, 12'(i * 16 + 1)));
      end
      ack_delay = 0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      obs_q.delete();
      #1 rst = 1'b0;
      run_cycles(4 * (STACK_DEPTH + 1) + 4);
      total_cnt++;
      if (obs_q.size() != exp_q.size())
         $display("[TB] FAIL ovf_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
      else pass_cnt++;
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
         total_cnt++;
         if (got !== want) $display("[TB] FAIL ovf_event: got %h want %h", got, want);
         else pass_cnt++;
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total_cnt++;
         if ({mem_req, halted, stack_err} !== 3'b011)
            $display("[TB] FAIL ovf_halted: got req=%b halted=%b err=%b want 0 1 1", mem_req, halted, stack_err);
         else pass_cnt++;
      end
   endtask

   task automatic test_stack_underflow();
      logic [31:0] want, got;
      clear_prog();
      prog[0] = 8'hE0;
      ack_delay = 0;
      do_reset();
      total_cnt++;
      if (stack_err !== 1'b0) $display("[TB] FAIL unf_err_cleared: got %b want 0", stack_err);
      else pass_cnt++;
      exp_q.push_back(ev(1, K_MEM, 12'h000));
      run_cycles(6);
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
         total_cnt++;
         if (got !== want) $display("[TB] FAIL unf_event: got %h want %h", got, want);
         else pass_cnt++;
      end
      total_cnt++;
      if ({halted, stack_err, mem_req} !== 3'b110)
         $display("[TB] FAIL unf_state: got halted=%b err=%b req=%b want 1 1 0", halted, stack_err, mem_req);
      else pass_cnt++;
   endtask

   task automatic test_load_wait();
      logic [31:0] want, got;
      logic        prev_pending;
      logic [7:0]  prev_addr;
      int          stable_bad;
      int          pulse_bad;
      clear_prog();
      prog[0]     = 8'h18;
      prog[1]     = 8'h40;
      prog[8'h40] = 8'h5A;
      ack_delay = 3;
      do_reset();
      exp_q.push_back(ev(4,  K_MEM, 12'h000));
      exp_q.push_back(ev(9,  K_MEM, 12'h001));
      exp_q.push_back(ev(13, K_MEM, 12'h040));
      exp_q.push_back(ev(13, K_REG, 12'h014));
      exp_q.push_back(ev(17, K_MEM, 12'h002));
      prev_pending = 1'b0;
      prev_addr    = 8'h00;
      stable_bad   = 0;
      pulse_bad    = 0;
      repeat (22) begin
         @(negedge clk);
         if (prev_pending && (!mem_req || mem_addr !== prev_addr)) stable_bad++;
         if (reg_load != '0 && !mem_ack) pulse_bad++;
         prev_pending = mem_req && !mem_ack;
         prev_addr    = mem_addr;
      end
      total_cnt++;
      if (stable_bad != 0) $display("[TB] FAIL wait_addr_stable: got %0d unstable cycles want 0", stable_bad);
      else pass_cnt++;
      total_cnt++;
      if (pulse_bad != 0) $display("[TB] FAIL wait_pulse_in_ack: got %0d early pulses want 0", pulse_bad);
      else pass_cnt++;
      total_cnt++;
      if (obs_q.size() != exp_q.size())
         $display("[TB] FAIL wait_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
      else pass_cnt++;
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
         total_cnt++;
         if (got !== want) $display("[TB] FAIL wait_event: got %h want %h", got, want);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_during_wait();
      logic [31:0] want, got;
      logic [19:0] outs;
      clear_prog();
      prog[0] = 8'h18;
      prog[1] = 8'h40;
      ack_delay = 3;
      do_reset();
      repeat (11) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      outs = {mem_req, reg_load, out_load, alu_en, bus_sel, alu_op,
              alu_a_sel, alu_b_sel, alu_shift, halted, stack_err, mem_addr[1:0]};
      total_cnt++;
      if (outs !== 20'd0) $display("[TB] FAIL midreset_outputs: got %h want 0", outs);
      else pass_cnt++;
      do_reset();
      exp_q.push_back(ev(4, K_MEM, 12'h000));
      run_cycles(6);
      want = exp_q.pop_front();
      got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFFFFFF;
      total_cnt++;
      if (got !== want) $display("[TB] FAIL midreset_refetch: got %h want %h", got, want);
      else pass_cnt++;
   endtask

   initial begin
      clk        = 1'b0;
      rst        = 1'b1;
      zero_flag  = 1'b0;
      carry_flag = 1'b0;
      sign_flag  = 1'b0;
      ack_delay  = 0;
      idle_bad   = 0;
      pass_cnt   = 0;
      total_cnt  = 0;
      clear_prog();

      test_reset();
      test_zero_wait();
      test_jump("rel_wrap", 8'h80, 8'hFE, 1'b0, 1'b0, 1'b0, 8'hFF);
      test_jump("cond_nt",  8'h90, 8'h10, 1'b0, 1'b1, 1'b1, 8'h02);
      test_jump("cond_tk",  8'h90, 8'h10, 1'b1, 1'b0, 1'b0, 8'h11);
      test_jump("abs_carry", 8'hA8, 8'h33, 1'b0, 1'b1, 1'b0, 8'h33);
      test_call_return();
      test_stack_overflow();
      test_stack_underflow();
      test_load_wait();
      test_reset_during_wait();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
